// File: rtl/joystick_adc_scan_ctrl.sv
// Joystick ADC scan controller: periodically samples X then Y over Avalon-ST,
// matches responses, IIR-filters each axis and flags timeout/channel faults.
module joystick_adc_scan_ctrl #(
  parameter int unsigned CH_X        = 1,
  parameter int unsigned CH_Y        = 2,
  parameter int unsigned SCAN_PERIOD = 50000,
  parameter int unsigned TIMEOUT     = 1023,
  parameter int unsigned AVG_SHIFT   = 2
) (
  input  logic        clock_clk,
  input  logic        reset_sink_reset,
  input  logic        enable,
  input  logic        adc_pll_locked,
  output logic        command_valid,
  output logic [4:0]  command_channel,
  output logic        command_startofpacket,
  output logic        command_endofpacket,
  input  logic        command_ready,
  input  logic        response_valid,
  input  logic [4:0]  response_channel,
  input  logic [11:0] response_data,
  output logic [11:0] joy_x,
  output logic [11:0] joy_y,
  output logic        joy_valid,
  output logic        timeout_err,
  output logic        chan_err
);

  localparam int unsigned PW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(SCAN_PERIOD - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT);
  localparam logic [4:0]    CHX    = 5'(CH_X);
  localparam logic [4:0]    CHY    = 5'(CH_Y);

  typedef enum logic [2:0] {
    S_WAIT_LOCK, S_IDLE, S_CMD_X, S_RESP_X, S_CMD_Y, S_RESP_Y
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_pcnt;
  logic [TW-1:0]   r_tcnt;
  logic            r_first_x;
  logic            r_first_y;
  logic            r_y_done;

  logic            w_in_resp;
  logic [4:0]      w_exp_ch;
  logic            w_match;
  logic            w_period_done;
  logic            w_timeout;
  logic            w_accept;
  logic            w_scan_start;

  assign w_in_resp     = (r_state == S_RESP_X) || (r_state == S_RESP_Y);
  assign w_exp_ch      = (r_state == S_RESP_Y) ? CHY : CHX;
  assign w_match       = response_valid && w_in_resp && (response_channel == w_exp_ch);
  assign w_period_done = (r_pcnt == P_LAST);
  assign w_timeout     = (r_tcnt == T_LAST);
  assign w_accept      = command_valid && command_ready;
  assign w_scan_start  = adc_pll_locked && (r_state == S_IDLE) && enable && w_period_done;

  assign command_startofpacket = command_valid;
  assign command_endofpacket   = command_valid;

  // y + ((s - y) >>> AVG_SHIFT) on 13-bit signed difference; stays within 0..4095
  function automatic logic [11:0] iir(input logic [11:0] y, input logic [11:0] s);
    logic signed [12:0] d;
    logic signed [12:0] sum;
    d   = $signed({1'b0, s}) - $signed({1'b0, y});
    sum = $signed({1'b0, y}) + (d >>> AVG_SHIFT);
    return 12'(sum);
  endfunction

  // Period counter saturates at its last value so at most one late scan is pending
  always_ff @(posedge clock_clk or posedge reset_sink_reset) begin
    if (reset_sink_reset) begin
      r_pcnt <= '0;
    end else if (w_scan_start) begin
      r_pcnt <= '0;
    end else if (!w_period_done) begin
      r_pcnt <= r_pcnt + PW'(1);
    end
  end

  always_ff @(posedge clock_clk or posedge reset_sink_reset) begin
    if (reset_sink_reset) begin
      r_state         <= S_WAIT_LOCK;
      r_tcnt          <= '0;
      r_first_x       <= 1'b1;
      r_first_y       <= 1'b1;
      r_y_done        <= 1'b0;
      command_valid   <= 1'b0;
      command_channel <= 5'd0;
      joy_x           <= 12'h800;
      joy_y           <= 12'h800;
      joy_valid       <= 1'b0;
      timeout_err     <= 1'b0;
      chan_err        <= 1'b0;
    end else begin
      joy_valid <= r_y_done;
      r_y_done  <= 1'b0;
      if (response_valid && !w_match) begin
        chan_err <= 1'b1;
      end
      // Lock loss overrides everything, including a same-cycle handshake
      if (!adc_pll_locked) begin
        r_state       <= S_WAIT_LOCK;
        command_valid <= 1'b0;
        r_first_x     <= 1'b1;
        r_first_y     <= 1'b1;
      end else begin
        case (r_state)
          S_WAIT_LOCK: r_state <= S_IDLE;
          S_IDLE: begin
            if (w_scan_start) begin
              r_state         <= S_CMD_X;
              command_valid   <= 1'b1;
              command_channel <= CHX;
            end
          end
          S_CMD_X, S_CMD_Y: begin
            if (w_accept) begin
              command_valid <= 1'b0;
              r_tcnt        <= '0;
              r_state       <= (r_state == S_CMD_X) ? S_RESP_X : S_RESP_Y;
            end
          end
          S_RESP_X: begin
            r_tcnt <= r_tcnt + TW'(1);
            if (w_match || w_timeout) begin
              if (w_match) begin
                joy_x     <= r_first_x ? response_data : iir(joy_x, response_data);
                r_first_x <= 1'b0;
              end else begin
                timeout_err <= 1'b1;
              end
              r_state         <= S_CMD_Y;
              command_valid   <= 1'b1;
              command_channel <= CHY;
            end
          end
          S_RESP_Y: begin
            r_tcnt <= r_tcnt + TW'(1);
            if (w_match) begin
              joy_y     <= r_first_y ? response_data : iir(joy_y, response_data);
              r_first_y <= 1'b0;
              r_y_done  <= 1'b1;
              r_state   <= S_IDLE;
            end else if (w_timeout) begin
              timeout_err <= 1'b1;
              r_state     <= S_IDLE;
            end
          end
          default: r_state <= S_WAIT_LOCK;
        endcase
      end
    end
  end

endmodule
